// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
//
// Contents:
//   fetch_state_e : FETCH (nothing outstanding), WAIT (response will be kept),
//                   DRAIN (response will be thrown away after a redirect)
//   PC_INC        : byte stride between sequential fetches
//   NOP_INSTR     : canonical no-op encoding for idle-slot comparisons
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - one-entry IF/ID holding register
//
// Ports:
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   flush_i              : kill the held instruction (redirect)
//   load_i               : capture a fresh fetch response
//   consume_i            : decode takes the held instruction this cycle
//   pc_i, instr_i        : fetch response to capture
//   valid_o, pc_o, instr_o : held entry
// Priority: reset > flush > load > consume; otherwise hold.
module if_id_reg #(
    parameter int PC_W = 9
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            consume_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, single-outstanding imem fetch and redirect handling
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall_i               : decode hazard, IF/ID must hold
//   pc_sel_i, br_pc_i     : redirect request and target byte address
//   imem_req_o/addr_o     : fetch request and byte address
//   imem_gnt_i            : request accepted this cycle
//   imem_rvalid_i/rdata_i : response
//   if_valid_o/pc_o/instr_o : IF/ID contents presented to decode
//   flush_o               : kill younger pipeline contents (same cycle as pc_sel_i)
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            pc_sel_i,
    input  logic [31:0]     br_pc_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [PC_W-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            flush_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

    logic            accept;
    logic            resp_keep;
    logic [PC_W-1:0] redirect_pc;
    logic            unused_br_bits;

    // Only the in-range word address of the target matters.
    assign redirect_pc    = {br_pc_i[PC_W-1:2], 2'b00};
    assign unused_br_bits = ^{br_pc_i[31:PC_W], br_pc_i[1:0]};

    // A new request needs an idle fetch path, no redirect this cycle, and
    // room in IF/ID (empty, or being consumed this cycle).
    assign imem_req_o  = !reset && (state_q == FETCH) && !pc_sel_i
                         && (!if_valid_o || !stall_i);
    assign imem_addr_o = pc_q;
    assign accept      = imem_req_o && imem_gnt_i;
    assign flush_o     = pc_sel_i;

    // Responses are kept only in WAIT and only when no redirect kills them.
    assign resp_keep   = (state_q == WAIT) && imem_rvalid_i && !pc_sel_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if (pc_sel_i) begin
            pc_d = redirect_pc;
            // An outstanding response must still be absorbed before the
            // target can be requested, unless it arrives right now.
            if (state_q != FETCH) begin
                state_d = imem_rvalid_i ? FETCH : DRAIN;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        pc_d       = pc_q + PC_W'(PC_INC);
                        fetch_pc_d = pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) state_d = FETCH;
                end
                DRAIN: begin
                    if (imem_rvalid_i) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    if_id_reg #(
        .PC_W(PC_W)
    ) u_if_id (
        .clk_i    (clk),
        .reset_i  (reset),
        .flush_i  (pc_sel_i),
        .load_i   (resp_keep),
        .consume_i(!stall_i),
        .pc_i     (fetch_pc_q),
        .instr_i  (imem_rdata_i),
        .valid_o  (if_valid_o),
        .pc_o     (if_pc_o),
        .instr_o  (if_instr_o)
    );

endmodule
